time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Mode sequencer for the HH:MM clock datapath: steps RUN -> SET_HR -> SET_MIN -> RUN
//  on a mode button; converts an up-button level into single-cycle hour/minute increment
//  pulses with hold-to-auto-repeat; gates the clock enable; drives a digit-blink mask
//  for the seven-segment driver. Sits between the debouncers and digital_clock/sevenseg_driver.
// PARAMETERS
//  CLK_HZ      100_000_000  input clock frequency; ms tick = CLK_HZ/1000 cycles
//  HOLD_MS     500          up held this long (ms) before auto-repeat starts
//  REPEAT_MS   100          auto-repeat period (ms)
//  BLINK_MS    250          blink half-period (ms) of the field being set
//  TIMEOUT_MS  10_000       inactivity (ms) in a set state before forced return to RUN
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  run_sw     in   1  run enable switch (level)
//  mode_btn   in   1  debounced mode button (level)
//  up_btn     in   1  debounced increment button (level)
//  clk_en     out  1  enable to digital_clock; registered, = run_sw & (state==RUN)
//  hrup       out  1  one-cycle hour increment pulse
//  minup      out  1  one-cycle minute increment pulse
//  sec_clr    out  1  one-cycle pulse clearing seconds on exit from SET_MIN
//  blank      out  4  per-digit blank {h2,h1,m2,m1}; 1 = digit off
//  mode       out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 unused, decodes to RUN)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. Reset: state RUN, all outputs 0,
//    all counters/edge registers 0, blink phase = on.
//  - Edge detect internal: press = level 1 now, registered previous level 0.
//  - All outputs registered; a press sampled at edge N produces its pulse/state change at N+1.
//  - RUN: mode press -> SET_HR. up ignored. clk_en follows run_sw (1-cycle latency).
//  - SET_HR: clk_en=0. up press -> hrup 1 cycle. mode press -> SET_MIN.
//  - SET_MIN: clk_en=0. up press -> minup 1 cycle. mode press -> RUN + sec_clr 1 cycle.
//  - Auto-repeat: up held continuously HOLD_MS ms after press -> one increment pulse,
//    then one every REPEAT_MS ms while held; release clears hold counter immediately.
//  - mode and up press in same cycle: mode wins, up press discarded, no increment.
//  - Mode change while up held: repeat stops; new state needs fresh up press.
//  - Blink: phase toggles every BLINK_MS ms in set states; off-phase blanks field digits
//    (SET_HR -> 1100, SET_MIN -> 0011). Phase forced on at state entry and at every
//    increment pulse. RUN -> blank=0000.
//  - Timeout: no press/hold in set state for TIMEOUT_MS ms -> RUN, sec_clr NOT pulsed.
//  - Counters saturate; ms counter width $clog2(CLK_HZ/1000), ms counters $clog2(TIMEOUT_MS+1).
//  - reset mid-hold or mid-set: immediate return to reset values, no pending pulse emitted.
//  - hrup/minup never both high; at most one pulse per cycle.
// STRUCTURE
//  - Shared package clk_pkg: mode encoding constants (MODE_RUN/SET_HR/SET_MIN),
//    blank mask constants.
//  - Sub-module ms_tick_gen (clk, reset, tick): one-cycle pulse every CLK_HZ/1000 cycles.
//  - FSM, edge detect, repeat/blink/timeout counters in this module.
// TESTING (CLK_HZ=10_000 -> 10 cycles/ms; HOLD_MS=5, REPEAT_MS=2, BLINK_MS=3, TIMEOUT_MS=50)
//  - reset high 3 cycles with buttons high -> all outputs 0, mode=00; release -> no pulses.
//  - run_sw=1, mode presses x3 -> mode 01,10,00 each 1 cycle after press; clk_en 0 in set
//    states, sec_clr single pulse on 10->00 transition.
//  - SET_HR, up tap 1 cycle -> exactly one hrup 1 cycle later; hold 100 cycles -> first
//    repeat at ~50 cycles, then every 20 cycles (3 repeats total + initial).
//  - SET_MIN, mode and up press same cycle -> mode=00, minup never asserted.
//  - SET_HR idle -> blank toggles 1100/0000 every 30 cycles; up press forces 0000; after
//    500 cycles idle -> mode=00, sec_clr stays 0.
//  - reset asserted during up hold in SET_MIN -> next cycle mode=00, no minup thereafter.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared encodings for the HH:MM clock set controller: mode values and digit-blank masks.
package clk_pkg;

  typedef enum logic [1:0] {
    ModeRun    = 2'b00,
    ModeSetHr  = 2'b01,
    ModeSetMin = 2'b10
  } mode_e;

  // Blank mask order is {h2, h1, m2, m1}; a 1 turns the digit off.
  localparam logic [3:0] BlankNone    = 4'b0000;
  localparam logic [3:0] BlankHours   = 4'b1100;
  localparam logic [3:0] BlankMinutes = 4'b0011;

  function automatic logic [3:0] blank_mask(input mode_e mode, input logic phase_on);
    logic [3:0] mask;
    mask = BlankNone;
    if (!phase_on) begin
      if (mode == ModeSetHr) begin
        mask = BlankHours;
      end else if (mode == ModeSetMin) begin
        mask = BlankMinutes;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs and control outputs between the debouncers, the set controller and the clock.
interface time_set_ctrl_if;
  import clk_pkg::*;

  logic       run_sw;
  logic       mode_btn;
  logic       up_btn;
  logic       clk_en;
  logic       hrup;
  logic       minup;
  logic       sec_clr;
  logic [3:0] blank;
  mode_e      mode;

  modport master (
    output run_sw, mode_btn, up_btn,
    input  clk_en, hrup, minup, sec_clr, blank, mode
  );

  modport slave (
    input  run_sw, mode_btn, up_btn,
    output clk_en, hrup, minup, sec_clr, blank, mode
  );

endinterface

// File: rtl/time_set_ctrl_ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every Div clock cycles.
module ms_tick_gen #(
  parameter int unsigned Div = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CntMax);
    cnt_d  = tick_d ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode sequencer for the HH:MM clock: RUN -> SET_HR -> SET_MIN -> RUN, increment pulses with
// hold-to-repeat, blink mask for the field being set and an inactivity timeout.
module time_set_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned HOLD_MS    = 500,
  parameter int unsigned REPEAT_MS  = 100,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned TIMEOUT_MS = 10_000
) (
  input logic             clk,
  input logic             reset,
  time_set_ctrl_if.slave  bus
);

  localparam int unsigned TickDiv = CLK_HZ / 1000;
  localparam int unsigned MsW     = $clog2(TIMEOUT_MS + 1);

  typedef logic [MsW-1:0] ms_cnt_t;

  localparam ms_cnt_t HoldLim    = ms_cnt_t'(HOLD_MS);
  localparam ms_cnt_t RepeatLim  = ms_cnt_t'(REPEAT_MS);
  localparam ms_cnt_t BlinkLim   = ms_cnt_t'(BLINK_MS);
  localparam ms_cnt_t TimeoutLim = ms_cnt_t'(TIMEOUT_MS);

  logic tick;

  mode_e   state_q, state_d;
  logic    mode_prev_q, mode_prev_d;
  logic    up_prev_q, up_prev_d;
  logic    armed_q, armed_d;
  logic    rep_q, rep_d;
  ms_cnt_t hold_q, hold_d;
  ms_cnt_t idle_q, idle_d;
  ms_cnt_t blink_q, blink_d;
  logic    phase_q, phase_d;
  logic    clk_en_q, clk_en_d;
  logic    hrup_q, hrup_d;
  logic    minup_q, minup_d;
  logic    sec_clr_q, sec_clr_d;
  logic [3:0] blank_q, blank_d;

  logic    mode_press, up_press, in_set, pulse, timeout;
  ms_cnt_t hold_inc, idle_inc, blink_inc;

  ms_tick_gen #(
    .Div(TickDiv)
  ) u_ms_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign mode_press = bus.mode_btn & ~mode_prev_q;
  assign up_press   = bus.up_btn & ~up_prev_q;
  assign in_set     = (state_q == ModeSetHr) || (state_q == ModeSetMin);

  assign hold_inc  = (&hold_q)  ? hold_q  : hold_q + ms_cnt_t'(1);
  assign idle_inc  = (&idle_q)  ? idle_q  : idle_q + ms_cnt_t'(1);
  assign blink_inc = (&blink_q) ? blink_q : blink_q + ms_cnt_t'(1);

  always_comb begin
    state_d     = state_q;
    mode_prev_d = bus.mode_btn;
    up_prev_d   = bus.up_btn;
    armed_d     = armed_q;
    rep_d       = rep_q;
    hold_d      = hold_q;
    idle_d      = idle_q;
    blink_d     = blink_q;
    phase_d     = phase_q;
    sec_clr_d   = 1'b0;
    pulse       = 1'b0;
    timeout     = 1'b0;

    // A mode press always wins over up; it also kills any repeat in progress.
    if (!in_set || mode_press || !bus.up_btn) begin
      armed_d = 1'b0;
      rep_d   = 1'b0;
      hold_d  = '0;
    end else if (up_press) begin
      armed_d = 1'b1;
      rep_d   = 1'b0;
      hold_d  = '0;
      pulse   = 1'b1;
    end else if (armed_q && tick) begin
      if (hold_inc >= (rep_q ? RepeatLim : HoldLim)) begin
        pulse  = 1'b1;
        rep_d  = 1'b1;
        hold_d = '0;
      end else begin
        hold_d = hold_inc;
      end
    end

    // Holding up counts as activity even when it no longer produces pulses.
    if (!in_set || mode_press || bus.up_btn) begin
      idle_d = '0;
    end else if (tick) begin
      if (idle_inc >= TimeoutLim) begin
        timeout = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_inc;
      end
    end

    case (state_q)
      ModeSetHr: begin
        if (mode_press) begin
          state_d = ModeSetMin;
        end else if (timeout) begin
          state_d = ModeRun;
        end
      end
      ModeSetMin: begin
        if (mode_press) begin
          state_d   = ModeRun;
          sec_clr_d = 1'b1;
        end else if (timeout) begin
          state_d = ModeRun;
        end
      end
      default: begin
        state_d = mode_press ? ModeSetHr : ModeRun;
      end
    endcase

    if (state_d == ModeRun || state_d != state_q || pulse) begin
      phase_d = 1'b1;
      blink_d = '0;
    end else if (tick) begin
      if (blink_inc >= BlinkLim) begin
        phase_d = ~phase_q;
        blink_d = '0;
      end else begin
        blink_d = blink_inc;
      end
    end

    hrup_d   = pulse & (state_q == ModeSetHr);
    minup_d  = pulse & (state_q == ModeSetMin);
    clk_en_d = bus.run_sw & (state_d == ModeRun);
    blank_d  = blank_mask(state_d, phase_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ModeRun;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      rep_q       <= 1'b0;
      hold_q      <= '0;
      idle_q      <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b1;
      clk_en_q    <= 1'b0;
      hrup_q      <= 1'b0;
      minup_q     <= 1'b0;
      sec_clr_q   <= 1'b0;
      blank_q     <= BlankNone;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      up_prev_q   <= up_prev_d;
      armed_q     <= armed_d;
      rep_q       <= rep_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      clk_en_q    <= clk_en_d;
      hrup_q      <= hrup_d;
      minup_q     <= minup_d;
      sec_clr_q   <= sec_clr_d;
      blank_q     <= blank_d;
    end
  end

  assign bus.clk_en  = clk_en_q;
  assign bus.hrup    = hrup_q;
  assign bus.minup   = minup_q;
  assign bus.sec_clr = sec_clr_q;
  assign bus.blank   = blank_q;
  assign bus.mode    = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: directed scenarios plus random button activity against
// a millisecond-level behavioural model of the set controller.
module tb_time_set_ctrl;

  localparam int unsigned CLK_HZ     = 10_000;
  localparam int unsigned HOLD_MS    = 5;
  localparam int unsigned REPEAT_MS  = 2;
  localparam int unsigned BLINK_MS   = 3;
  localparam int unsigned TIMEOUT_MS = 50;
  localparam int          CYC_PER_MS = CLK_HZ / 1000;

  typedef struct packed {
    logic       clk_en;
    logic       hrup;
    logic       minup;
    logic       sec_clr;
    logic [3:0] blank;
    logic [1:0] mode;
  } out_t;

  logic clk;
  logic reset;

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .HOLD_MS   (HOLD_MS),
    .REPEAT_MS (REPEAT_MS),
    .BLINK_MS  (BLINK_MS),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_inc_n = 0;
  int   obs_inc_n = 0;

  // Model state, in milliseconds and "button still held since an accepted press" terms.
  int m_mode, m_edges, m_held_ms, m_idle_ms, m_blink_ms;
  bit m_pm, m_pu, m_held, m_on;

  task automatic model_step(input bit r, input bit rs, input bit mb, input bit ub);
    out_t e;
    bit   mp, upr, tick, pulse, sec;
    int   nm;
    if (r) begin
      m_mode = 0; m_edges = 0; m_held_ms = 0; m_idle_ms = 0; m_blink_ms = 0;
      m_pm = 0; m_pu = 0; m_held = 0; m_on = 1;
      e = '0;
      exp_q.push_back(e);
      return;
    end
    m_edges++;
    // ms tick becomes visible right after every CYC_PER_MS-th edge since reset
    tick  = (m_edges - 1 > 0) && ((m_edges - 1) % CYC_PER_MS == 0);
    mp    = mb && !m_pm;
    upr   = ub && !m_pu;
    m_pm  = mb;
    m_pu  = ub;
    pulse = 0;
    sec   = 0;
    nm    = m_mode;
    if (m_mode != 0 && !mp && ub) begin
      if (upr) begin
        pulse = 1; m_held = 1; m_held_ms = 0;
      end else if (m_held && tick) begin
        m_held_ms++;
        if (m_held_ms == HOLD_MS ||
            (m_held_ms > HOLD_MS && (m_held_ms - HOLD_MS) % REPEAT_MS == 0)) pulse = 1;
      end
    end else begin
      m_held = 0;
    end
    if (m_mode != 0 && !mp && !ub) begin
      if (tick) begin
        m_idle_ms++;
        if (m_idle_ms >= TIMEOUT_MS) nm = 0;
      end
    end else begin
      m_idle_ms = 0;
    end
    if (mp) begin
      nm  = (m_mode + 1) % 3;
      sec = (m_mode == 2);
    end
    if (nm == 0 || nm != m_mode || pulse) begin
      m_on = 1; m_blink_ms = 0;
    end else if (tick) begin
      m_blink_ms++;
      m_on = ((m_blink_ms / BLINK_MS) % 2) == 0;
    end
    e.clk_en  = rs && (nm == 0);
    e.hrup    = pulse && (m_mode == 1);
    e.minup   = pulse && (m_mode == 2);
    e.sec_clr = sec;
    e.blank   = (nm == 1 && !m_on) ? 4'b1100 : (nm == 2 && !m_on) ? 4'b0011 : 4'b0000;
    e.mode    = 2'(nm);
    if (pulse) exp_inc_n++;
    m_mode = nm;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit rs, input bit mb, input bit ub);
    @(negedge clk);
    reset        = r;
    bus.run_sw   = rs;
    bus.mode_btn = mb;
    bus.up_btn   = ub;
    @(posedge clk);
    model_step(r, rs, mb, ub);
  endtask

  task automatic hold(input int n, input bit r, input bit rs, input bit mb, input bit ub);
    for (int i = 0; i < n; i++) cycle(r, rs, mb, ub);
  endtask

  task automatic mode_tap(input bit rs);
    cycle(0, rs, 1, 0);
    hold(4, 0, rs, 0, 0);
  endtask

  // Monitor: the DUT presents a full output word every cycle.
  out_t act, exp_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act   = {bus.clk_en, bus.hrup, bus.minup, bus.sec_clr, bus.blank, bus.mode};
      if (act.hrup || act.minup) obs_inc_n++;
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t actual clk_en=%b hrup=%b minup=%b sec_clr=%b blank=%b mode=%b required clk_en=%b hrup=%b minup=%b sec_clr=%b blank=%b mode=%b",
                 $time, act.clk_en, act.hrup, act.minup, act.sec_clr, act.blank, act.mode,
                 exp_v.clk_en, exp_v.hrup, exp_v.minup, exp_v.sec_clr, exp_v.blank, exp_v.mode);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t actual still running required finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    bit rs, mb, ub, r;
    reset        = 1'b1;
    bus.run_sw   = 1'b0;
    bus.mode_btn = 1'b1;
    bus.up_btn   = 1'b1;

    // Reset with buttons high, then release everything together.
    hold(3, 1, 0, 1, 1);
    hold(6, 0, 0, 0, 0);

    // Full mode cycle with run enabled.
    hold(3, 0, 1, 0, 0);
    mode_tap(1);
    mode_tap(1);
    mode_tap(1);
    hold(5, 0, 1, 0, 0);

    // SET_HR: single tap, then a 100-cycle hold.
    mode_tap(1);
    cycle(0, 1, 0, 1);
    hold(10, 0, 1, 0, 0);
    hold(100, 0, 1, 0, 1);
    hold(5, 0, 1, 0, 0);

    // SET_MIN: mode and up pressed together.
    mode_tap(1);
    cycle(0, 1, 1, 1);
    hold(10, 0, 1, 0, 0);

    // SET_HR idle: blink, up press forcing on-phase, then timeout.
    mode_tap(1);
    hold(75, 0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    hold(560, 0, 1, 0, 0);

    // Reset in the middle of an up hold in SET_MIN.
    mode_tap(1);
    mode_tap(1);
    hold(70, 0, 1, 0, 1);
    hold(2, 1, 1, 0, 1);
    hold(40, 0, 1, 0, 1);
    hold(10, 0, 1, 0, 0);

    // Mode change while up held: no repeat in the new state without a fresh press.
    mode_tap(0);
    cycle(0, 0, 0, 1);
    hold(20, 0, 0, 0, 1);
    hold(80, 0, 0, 1, 1);
    hold(5, 0, 0, 0, 0);

    // Random button activity.
    for (int s = 0; s < 160; s++) begin
      len = $urandom_range(1, 60);
      rs  = 1'($urandom_range(0, 3) != 0);
      mb  = 1'($urandom_range(0, 4) == 0);
      ub  = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 50) == 0);
      if ($urandom_range(0, 15) == 0) begin
        len = 520;
        mb  = 0;
        ub  = 0;
      end
      for (int i = 0; i < len; i++) cycle(r && i < 2, rs, mb, ub);
    end
    hold(3, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    n_tests++;
    if (obs_inc_n != exp_inc_n) begin
      n_fail++;
      $display("FAIL pulse_count actual %0d required %0d", obs_inc_n, exp_inc_n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
